// File: rtl/output_layer_pkg.sv
// -----------------------------------------------------------------------------
// output_layer_pkg
// Shared definitions for the output-layer datapath blocks.
//   PROD_W              width of a signed multiplier product
//   ST_IDLE/ACCUM/HOLD  2-bit FSM state encodings for the neuron accumulator
//   state_t             enum over those encodings
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package output_layer_pkg;

  localparam int PROD_W = 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ACCUM = ST_ACCUM,
    S_HOLD  = ST_HOLD
  } state_t;

endpackage

// File: rtl/sat_signed.sv
// -----------------------------------------------------------------------------
// sat_signed
// Clamps a two's complement value of IN_W bits into OUT_W bits.
//   din   in   IN_W   signed input
//   dout  out  OUT_W  clamped result in [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   ovf   out  1      1 when din did not fit and dout was clamped
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sat_signed #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             ovf
);

  // The value fits when every bit from the output sign bit upward is a copy
  // of the same sign.
  logic [IN_W-OUT_W:0] hi;

  assign hi  = din[IN_W-1:OUT_W-1];
  assign ovf = !((&hi) || !(|hi));

  always_comb begin
    dout = din[OUT_W-1:0];
    if (ovf) begin
      dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                         : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/acc_int12_neuron.sv
// -----------------------------------------------------------------------------
// acc_int12_neuron
// Accumulates a stream of signed int12 products (one vector of N_TERMS terms
// per neuron) on top of a sign-extended bias and emits one signed OUT_W-bit
// pre-activation per vector over valid/ready.
//
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous active-high reset
//   in_valid     in   1       product valid
//   in_ready     out  1       block can accept a product (low in HOLD / reset)
//   in_data      in   12      signed product
//   in_last      in   1       final product of a vector
//   bias         in   BIAS_W  signed bias, used only on the first product
//   out_valid    out  1       result valid (state HOLD)
//   out_ready    in   1       consumer accepts result
//   out_data     out  OUT_W   signed result
//   out_ovf      out  1       result clamped (ACC_SAT_EN only, else 0)
//   out_len_err  out  1       vector length did not match N_TERMS
//
// Build option: define ACC_SAT_EN to saturate out_data to OUT_W bits and
// report clamping on out_ovf; otherwise out_data is the wrapped low bits.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module acc_int12_neuron
  import output_layer_pkg::*;
#(
  parameter int N_TERMS = 16,
  parameter int BIAS_W  = 16,
  parameter int ACC_W   = 20,
  parameter int OUT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [BIAS_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              out_len_err
);

  localparam int CNT_W = $clog2(N_TERMS + 1);

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;
  logic               at_full;
  logic               close_vec;
  logic               len_err_nxt;
  logic [OUT_W-1:0]   res_data;
  logic               res_ovf;

  // Ready depends only on registered state and rst, never on out_ready.
  assign in_ready  = !rst && (state != S_HOLD);
  assign out_valid = (state == S_HOLD);
  assign accept    = in_valid && in_ready;

  // Running sum including the product currently offered; the first product of
  // a vector starts from the bias instead of the stale accumulator.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    acc_base    = acc;
    cnt_nxt     = cnt + CNT_W'(1);
    if (state == S_IDLE) begin
      acc_base = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
      cnt_nxt  = CNT_W'(1);
    end
    acc_sum     = acc_base + {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
    at_full     = (cnt_nxt == CNT_W'(N_TERMS));
    // A vector closes on in_last or on its N_TERMS-th product; it is well
    // formed only when both happen together.
    close_vec   = in_last || at_full;
    len_err_nxt = in_last ^ at_full;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_ACCUM: begin
        if (accept) state_nxt = close_vec ? S_HOLD : S_ACCUM;
      end
      S_HOLD: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef ACC_SAT_EN
  sat_signed #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .din  (acc_sum),
    .dout (res_data),
    .ovf  (res_ovf)
  );
`else
  assign res_data = acc_sum[OUT_W-1:0];
  assign res_ovf  = 1'b0;
  generate
    if (OUT_W < ACC_W) begin : g_wrap
      // Upper accumulator bits are intentionally dropped when wrapping.
      logic unused_hi;
      assign unused_hi = ^acc_sum[ACC_W-1:OUT_W];
    end
  endgenerate
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_len_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc <= acc_sum;
        cnt <= cnt_nxt;
        // Result registers load only on the closing product and then hold
        // through HOLD and beyond.
        if (close_vec) begin
          out_data    <= res_data;
          out_ovf     <= res_ovf;
          out_len_err <= len_err_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_int12_neuron.sv
// -----------------------------------------------------------------------------
// tb_acc_int12_neuron
// Self-checking bench: a driver issues products and updates a behavioural
// vector-sum model that queues expected results; a monitor pops the queue on
// every output handshake. A second instance (N_TERMS=1, OUT_W=12) covers the
// narrow-output overflow corner. Honour ACC_SAT_EN the same way as the RTL.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acc_int12_neuron;

  localparam int N_TERMS = 16;
  localparam int BIAS_W  = 16;
  localparam int ACC_W   = 20;
  localparam int OUT_W   = 16;
  localparam int TIMEOUT = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [11:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic [BIAS_W-1:0] bias = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OUT_W-1:0]  out_data;
  logic              out_ovf;
  logic              out_len_err;

  logic              t4_in_valid = 1'b0;
  logic              t4_in_ready;
  logic [11:0]       t4_in_data = '0;
  logic              t4_in_last = 1'b0;
  logic [15:0]       t4_bias = '0;
  logic              t4_out_valid;
  logic              t4_out_ready = 1'b0;
  logic [11:0]       t4_out_data;
  logic              t4_out_ovf;
  logic              t4_out_len_err;

  acc_int12_neuron #(
    .N_TERMS(N_TERMS), .BIAS_W(BIAS_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_len_err(out_len_err)
  );

  acc_int12_neuron #(
    .N_TERMS(1), .BIAS_W(16), .ACC_W(20), .OUT_W(12)
  ) dut_narrow (
    .clk(clk), .rst(rst),
    .in_valid(t4_in_valid), .in_ready(t4_in_ready), .in_data(t4_in_data),
    .in_last(t4_in_last), .bias(t4_bias),
    .out_valid(t4_out_valid), .out_ready(t4_out_ready), .out_data(t4_out_data),
    .out_ovf(t4_out_ovf), .out_len_err(t4_out_len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             ovf;
    logic             len_err;
  } exp_t;

  exp_t   sb_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     m_cnt = 0;
  longint m_sum = 0;
  bit     ready_mode = 1'b0;   // 1: random backpressure
  logic   ready_force = 1'b0;  // value used when ready_mode is 0

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out after %0d cycles (t=%0t)", name, TIMEOUT, $time);
  endtask

  // Reference: plain integer sum, then wrap or clamp into OUT_W bits.
  function automatic exp_t make_exp(input longint s, input bit le);
    exp_t   e;
    longint omax;
    longint omin;
    omax      = (longint'(1) <<< (OUT_W-1)) - 1;
    omin      = -omax - 1;
    e.data    = OUT_W'(s);
    e.ovf     = 1'b0;
    e.len_err = le;
`ifdef ACC_SAT_EN
    if (s > omax) begin
      e.data = OUT_W'(omax);
      e.ovf  = 1'b1;
    end else if (s < omin) begin
      e.data = OUT_W'(omin);
      e.ovf  = 1'b1;
    end
`endif
    return e;
  endfunction

  // Stream rule: a vector ends at in_last or at its N_TERMS-th product.
  task automatic model_accept(input logic [11:0] d, input logic l, input logic [BIAS_W-1:0] b);
    if (m_cnt == 0) m_sum = longint'($signed(b));
    m_sum += longint'($signed(d));
    m_cnt++;
    if (l || m_cnt == N_TERMS) begin
      sb_q.push_back(make_exp(m_sum, l != (m_cnt == N_TERMS)));
      m_cnt = 0;
    end
  endtask

  // Offer one product; returns at posedge+1 after it was accepted.
  task automatic push_term(input logic [11:0] d, input logic l, input logic [BIAS_W-1:0] b);
    int waited;
    bit done;
    bit ok;
    waited   = 0;
    done     = 1'b0;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    bias     = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        ok   = 1'b1;
      end else begin
        waited++;
        if (waited > TIMEOUT) begin
          timeout_fail("accept_wait");
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (ok) model_accept(d, l, b);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Let the pending result drain, then return to stalling the output.
  task automatic release_result();
    int waited;
    waited      = 0;
    ready_force = 1'b1;
    @(negedge clk);
    while (out_valid && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (out_valid) timeout_fail("release_wait");
    ready_force = 1'b0;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: compare every output handshake against the scoreboard and make
  // sure nothing is accepted while a result is pending.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      check("hold_in_ready", in_ready, 0);
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got result %0h with empty queue", out_data);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_data", out_data, e.data);
          check("sb_ovf", out_ovf, e.ovf);
          check("sb_len_err", out_len_err, e.len_err);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] held;
    int waited;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_len_err", out_len_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // 1: bias 100 + 16 x 1024, one-cycle latency
    @(posedge clk);
    #1;
    for (int i = 0; i < N_TERMS; i++) begin
      push_term(12'd1024, i == N_TERMS-1, 16'd100);
      if (i == N_TERMS-2) check("t1_valid_before_last", out_valid, 0);
    end
    check("t1_valid_after_last", out_valid, 1);
    check("t1_data", out_data, 16'd16484);
    check("t1_ovf", out_ovf, 0);
    check("t1_len_err", out_len_err, 0);
    release_result();

    // 2: 16 x -1016, result held stable under backpressure
    for (int i = 0; i < N_TERMS; i++) push_term(12'hC08, i == N_TERMS-1, 16'd0);
    held = 16'hC080;  // -16256
    repeat (5) begin
      @(negedge clk);
      check("t2_valid", out_valid, 1);
      check("t2_data_stable", out_data, held);
      check("t2_in_ready", in_ready, 0);
    end
    release_result();

    // 3: early in_last after 3 products
    push_term(12'd5, 1'b0, 16'hFFFF);
    push_term(12'd6, 1'b0, 16'h1234);
    push_term(12'd7, 1'b1, 16'h4321);
    check("t3_data", out_data, 16'd17);
    check("t3_len_err", out_len_err, 1);
    release_result();

    // 4: narrow output, bias 2047 + 1
    t4_in_valid = 1'b1;
    t4_in_data  = 12'd1;
    t4_in_last  = 1'b1;
    t4_bias     = 16'd2047;
    @(negedge clk);
    check("t4_in_ready", t4_in_ready, 1);
    @(posedge clk);
    #1;
    t4_in_valid = 1'b0;
    check("t4_valid", t4_out_valid, 1);
`ifdef ACC_SAT_EN
    check("t4_data", t4_out_data, 12'h7FF);
    check("t4_ovf", t4_out_ovf, 1);
`else
    check("t4_data", t4_out_data, 12'h800);
    check("t4_ovf", t4_out_ovf, 0);
`endif
    check("t4_len_err", t4_out_len_err, 0);
    t4_out_ready = 1'b1;
    @(posedge clk);
    #1;
    t4_out_ready = 1'b0;
    check("t4_valid_drop", t4_out_valid, 0);

    // 5: reset mid-vector discards the partial sum
    for (int i = 0; i < 8; i++) push_term(12'(i * 37 + 100), 1'b0, 16'd5000);
    rst   = 1'b1;
    m_cnt = 0;
    @(negedge clk);
    check("t5_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N_TERMS; i++) push_term(12'd2, i == N_TERMS-1, 16'd0);
    check("t5_data", out_data, 16'd32);
    check("t5_len_err", out_len_err, 0);
    release_result();

    // 6: 100 random vectors with gaps and backpressure
    ready_mode = 1'b1;
    for (int v = 0; v < 100; v++) begin
      int len;
      logic [BIAS_W-1:0] b;
      len = $urandom_range(1, N_TERMS);
      if ($urandom_range(0, 1) == 0) len = N_TERMS;
      b = BIAS_W'($urandom);
      for (int k = 1; k <= len; k++) begin
        logic l;
        l = (k == len) && ((len < N_TERMS) || ($urandom_range(0, 3) != 0));
        push_term(12'($urandom), l, b);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    waited = 0;
    while ((sb_q.size() != 0 || out_valid) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("t6_drained", sb_q.size(), 0);
    ready_mode = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
